rx_sample_reader: RTL and testbench

Consumer end of the receiver DDC's sample output port. On each one-cycle `rx_avail` strobe it walks the receiver's word-select lines (`rd_getI`, `rd_getQ`) to read the three 16-bit words of one sample, and reassembles signed 24-bit I and Q. It then queues the sample in a small FIFO and presents it downstream with a valid/ready handshake. It sits in the `adc_clk` domain, between the receiver output and the sample-packing/CPU-transfer logic.

---
 rtl/rx_sample_reader.sv | 148 ++++++++++++++
 tb/tb_rx_sample_reader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_reader.sv
// rx_sample_reader: reads one I/Q sample from the receiver DDC output port
// by walking its word selects. It rebuilds signed 24-bit I and Q, queues the
// sample in a small FIFO and presents it downstream with valid/ready.
// Drops are tracked in sticky flags and in a saturating counter.
module rx_sample_reader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          adc_clk,
    input  logic          reset_n,
    input  logic          rx_avail,
    input  logic [15:0]   rx_dout,
    output logic          rd_getI,
    output logic          rd_getQ,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [23:0]   out_i,
    output logic [23:0]   out_q,
    output logic [AW:0]   fifo_level,
    output logic          overrun,
    output logic          collision,
    output logic [15:0]   drop_count,
    input  logic          clr_stats
);

    typedef enum logic [2:0] {IDLE, GET_I, GET_Q, GET_X, PUSH} state_t;

    typedef struct packed {
        logic [23:0] i;
        logic [23:0] q;
    } sample_t;

    state_t      state;
    logic [15:0] i_lo, q_lo, x;

    sample_t     mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    sample_t     wr_sample, head, last;
    logic        push, full, empty, do_rd, do_wr, collide, drop_ovr;

    // Upper bytes of I and Q arrive together in the third word
    assign wr_sample = '{i: {x[15:8], i_lo}, q: {x[7:0], q_lo}};
    assign push      = (state == PUSH);

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd     = !empty && out_ready;
    // A full FIFO still takes the write when the head leaves the same cycle
    assign do_wr     = push && (!full || do_rd);
    assign drop_ovr  = push && full && !do_rd;
    assign collide   = rx_avail && (state inside {GET_I, GET_Q, GET_X});

    assign out_valid  = !empty;
    assign fifo_level = wr_ptr - rd_ptr;
    assign head       = mem[rd_ptr[AW-1:0]];
    // Once drained, keep showing the last sample that left rather than stale RAM
    assign out_i      = empty ? last.i : head.i;
    assign out_q      = empty ? last.q : head.q;

    // Capture FSM; word selects are registered decodes of the next state
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rd_getI <= 1'b0;
            rd_getQ <= 1'b0;
            i_lo    <= '0;
            q_lo    <= '0;
            x       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_avail) begin
                        state   <= GET_I;
                        rd_getI <= 1'b1;
                    end
                end
                GET_I: begin
                    i_lo    <= rx_dout;
                    state   <= GET_Q;
                    rd_getI <= 1'b0;
                    rd_getQ <= 1'b1;
                end
                GET_Q: begin
                    q_lo    <= rx_dout;
                    state   <= GET_X;
                    rd_getQ <= 1'b0;
                end
                GET_X: begin
                    x     <= rx_dout;
                    state <= PUSH;
                end
                PUSH: begin
                    if (rx_avail) begin
                        state   <= GET_I;
                        rd_getI <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rd_getI <= 1'b0;
                    rd_getQ <= 1'b0;
                end
            endcase
        end
    end

    // Sample storage; contents need no reset, validity comes from the pointers
    always_ff @(posedge adc_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_sample;
    end

    // FIFO pointers, plus the last sample handed downstream
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                last   <= head;
            end
        end
    end

    // Drop statistics; a clear wins over a drop in the same cycle
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun    <= 1'b0;
            collision  <= 1'b0;
            drop_count <= '0;
        end else if (clr_stats) begin
            overrun    <= 1'b0;
            collision  <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop_ovr) overrun   <= 1'b1;
            if (collide)  collision <= 1'b1;
            if ((drop_ovr || collide) && drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rx_sample_reader.sv
// Bench for rx_sample_reader: behavioural receiver port model, directed
// stimulus, and a scoreboard queue drained by an independent output monitor.
module tb_rx_sample_reader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          adc_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_avail = 1'b0;
    logic [15:0]   rx_dout;
    logic          rd_getI, rd_getQ, out_valid;
    logic          out_ready = 1'b0;
    logic [23:0]   out_i, out_q;
    logic [AW:0]   fifo_level;
    logic          overrun, collision;
    logic [15:0]   drop_count;
    logic          clr_stats = 1'b0;

    logic [23:0]   rec_i = '0, rec_q = '0;
    logic [47:0]   sb[$];
    int            total = 0, bad = 0;

    rx_sample_reader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .adc_clk(adc_clk), .reset_n(reset_n), .rx_avail(rx_avail),
        .rx_dout(rx_dout), .rd_getI(rd_getI), .rd_getQ(rd_getQ),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
        .out_q(out_q), .fifo_level(fifo_level), .overrun(overrun),
        .collision(collision), .drop_count(drop_count), .clr_stats(clr_stats)
    );

    always #5 adc_clk = ~adc_clk;

    // Receiver output mux: third word carries the upper bytes of I and Q
    always_comb begin
        rx_dout = {rec_i[23:16], rec_q[23:16]};
        if (rd_getI)      rx_dout = rec_i[15:0];
        else if (rd_getQ) rx_dout = rec_q[15:0];
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    // Strobe at cycle T, then idle three cycles so the next strobe lands in PUSH
    task automatic send(input logic [23:0] i, input logic [23:0] q);
        rec_i = i;
        rec_q = q;
        rx_avail = 1'b1;
        tick();
        rx_avail = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 48'(sb.size()), 48'd0);
    endtask

    // Monitor: every accepted output is checked against the oldest expectation
    always @(negedge adc_clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {out_i, out_q}, 48'hx);
            end else begin
                chk("sample", {out_i, out_q}, sb.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_sel",   {rd_getI, rd_getQ}, 2'b00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_flags", {overrun, collision, drop_count}, 0);
        chk("rst_data",  {out_i, out_q}, 48'd0);
        reset_n = 1'b1;
        tick();

        // Single sample with select timing
        rec_i = 24'h123456; rec_q = 24'hFEDCBA;
        rx_avail = 1'b1;
        tick();                                     // T+1
        rx_avail = 1'b0;
        chk("t1_sel", {rd_getI, rd_getQ}, 2'b10);
        tick();                                     // T+2
        chk("t2_sel", {rd_getI, rd_getQ}, 2'b01);
        tick();                                     // T+3
        chk("t3_sel", {rd_getI, rd_getQ}, 2'b00);
        tick();                                     // T+4
        chk("t4_valid", out_valid, 1'b0);
        tick();                                     // T+5
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data",  {out_i, out_q}, 48'h123456_FEDCBA);
        chk("t5_level", fifo_level, 1);
        sb.push_back(48'h123456_FEDCBA);
        drain("single_drain");
        out_ready = 1'b0;
        tick();
        chk("hold_data", {out_i, out_q}, 48'h123456_FEDCBA);

        // 100 back-to-back samples at the minimum spacing
        out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            logic [23:0] vi, vq;
            vi = {8'(k ^ 8'hA5), 16'(k * 331 + 7)};
            vq = {8'(8'h80 + k), 16'(16'hF000 - k * 59)};
            sb.push_back({vi, vq});
            send(vi, vq);
        end
        drain("b2b_drain");
        chk("b2b_drops", drop_count, 0);

        // Collision at T+2
        rec_i = 24'h800001; rec_q = 24'h7FFFFF;
        sb.push_back(48'h800001_7FFFFF);
        rx_avail = 1'b1; tick();
        rx_avail = 1'b0; tick();
        rx_avail = 1'b1; tick();
        rx_avail = 1'b0; repeat (6) tick();
        drain("coll_drain");
        chk("coll_flags", {overrun, collision}, 2'b01);
        chk("coll_count", drop_count, 1);

        // Overflow: DEPTH+3 samples with no reader
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        chk("clr_stats", {overrun, collision, drop_count}, 0);
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 3; k++) begin
            logic [23:0] vi, vq;
            vi = 24'h010000 * k + 24'h000111;
            vq = 24'hFF0000 - 24'h000222 * k;
            if (k < DEPTH) sb.push_back({vi, vq});
            send(vi, vq);
        end
        repeat (2) tick();
        chk("ovf_level", fifo_level, DEPTH);
        chk("ovf_flag",  overrun, 1'b1);
        chk("ovf_count", drop_count, 3);
        chk("ovf_head",  {out_i, out_q}, 48'h000111_FF0000);

        // Full FIFO: pop in the PUSH cycle lets the new sample in
        rec_i = 24'hABCDEF; rec_q = 24'h013579;
        sb.push_back(48'hABCDEF_013579);
        rx_avail = 1'b1; tick();
        rx_avail = 1'b0; repeat (3) tick();        // now T+4 (PUSH)
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        chk("full_pp_level", fifo_level, DEPTH);
        chk("full_pp_count", drop_count, 3);
        drain("ovf_drain");

        // Reset mid-capture
        out_ready = 1'b0;
        rec_i = 24'h555555; rec_q = 24'hAAAAAA;
        rx_avail = 1'b1; tick();
        rx_avail = 1'b0; tick();                    // T+2
        reset_n = 1'b0; #1;
        chk("mrst_sel",   {rd_getI, rd_getQ}, 2'b00);
        chk("mrst_out",   {out_valid, fifo_level}, 0);
        chk("mrst_stats", {overrun, collision, drop_count}, 0);
        chk("mrst_data",  {out_i, out_q}, 48'd0);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("mrst_idle", {out_valid, rd_getI, rd_getQ}, 3'b000);
        rec_i = 24'h0F0F0F; rec_q = 24'hF0F0F0;
        sb.push_back(48'h0F0F0F_F0F0F0);
        send(rec_i, rec_q);
        drain("mrst_drain");

        // Clear in the same cycle as a collision drop
        rec_i = 24'h246802; rec_q = 24'h135791;
        sb.push_back(48'h246802_135791);
        rx_avail = 1'b1; tick();
        rx_avail = 1'b0; tick();
        rx_avail = 1'b1; clr_stats = 1'b1; tick();
        rx_avail = 1'b0; clr_stats = 1'b0; tick();
        chk("clr_drop", {overrun, collision, drop_count}, 0);
        drain("clr_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a stuck DUT cannot hang the run
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
